// File: rtl/axis_mt_prng_pkg.sv
// rtl/axis_mt_prng_pkg.sv - MT19937 / MT19937-64 constants selected by word width, and the controller state enum.
package axis_mt_prng_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEED = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam logic [63:0] DEFAULT_SEED = 64'd5489;

    function automatic int mt_n(input int w);
        return (w == 64) ? 312 : 624;
    endfunction

    function automatic int mt_m(input int w);
        return (w == 64) ? 156 : 397;
    endfunction

    function automatic int mt_seed_shift(input int w);
        return (w == 64) ? 62 : 30;
    endfunction

    function automatic logic [63:0] mt_f(input int w);
        return (w == 64) ? 64'd6364136223846793005 : 64'd1812433253;
    endfunction

    function automatic logic [63:0] mt_a(input int w);
        return (w == 64) ? 64'hB502_6F5A_A966_19E9 : 64'h0000_0000_9908_B0DF;
    endfunction

    function automatic logic [63:0] mt_upper(input int w);
        return (w == 64) ? 64'hFFFF_FFFF_8000_0000 : 64'h0000_0000_8000_0000;
    endfunction

    function automatic int mt_u(input int w);
        return (w == 64) ? 29 : 11;
    endfunction

    function automatic logic [63:0] mt_d(input int w);
        return (w == 64) ? 64'h5555_5555_5555_5555 : 64'h0000_0000_FFFF_FFFF;
    endfunction

    function automatic int mt_s(input int w);
        return (w == 64) ? 17 : 7;
    endfunction

    function automatic logic [63:0] mt_b(input int w);
        return (w == 64) ? 64'h71D6_7FFF_EDA6_0000 : 64'h0000_0000_9D2C_5680;
    endfunction

    function automatic int mt_t(input int w);
        return (w == 64) ? 37 : 15;
    endfunction

    function automatic logic [63:0] mt_c(input int w);
        return (w == 64) ? 64'hFFF7_EEE0_0000_0000 : 64'h0000_0000_EFC6_0000;
    endfunction

    function automatic int mt_l(input int w);
        return (w == 64) ? 43 : 18;
    endfunction

endpackage

// File: rtl/axis_mt_prng_temper.sv
// rtl/axis_mt_prng_temper.sv - combinational Mersenne Twister output tempering for MT_W of 32 or 64.
module axis_mt_prng_temper
    import axis_mt_prng_pkg::*;
#(
    parameter int MT_W = 32
) (
    input  logic [MT_W-1:0] y_i,
    output logic [MT_W-1:0] z_o
);

    localparam logic [63:0]     D64 = mt_d(MT_W);
    localparam logic [63:0]     B64 = mt_b(MT_W);
    localparam logic [63:0]     C64 = mt_c(MT_W);
    localparam logic [MT_W-1:0] D   = D64[MT_W-1:0];
    localparam logic [MT_W-1:0] B   = B64[MT_W-1:0];
    localparam logic [MT_W-1:0] C   = C64[MT_W-1:0];
    localparam int              U   = mt_u(MT_W);
    localparam int              S   = mt_s(MT_W);
    localparam int              T   = mt_t(MT_W);
    localparam int              L   = mt_l(MT_W);

    logic [MT_W-1:0] y1;
    logic [MT_W-1:0] y2;
    logic [MT_W-1:0] y3;

    assign y1  = y_i ^ ((y_i >> U) & D);
    assign y2  = y1 ^ ((y1 << S) & B);
    assign y3  = y2 ^ ((y2 << T) & C);
    assign z_o = y3 ^ (y3 >> L);

endmodule

// File: rtl/axis_mt_prng.sv
// rtl/axis_mt_prng.sv - AXI4-Stream Mersenne Twister source (MT19937 / MT19937-64) with optional tlast packets.
// Define AXIS_MT_PRNG_DEFAULT_SEED_EN to self-seed with 5489 when reset is released.
module axis_mt_prng
    import axis_mt_prng_pkg::*;
#(
    parameter int MT_W    = 32,
    parameter int PKT_LEN = 0
) (
    input  logic            clk,
    input  logic            rst,
    output logic [MT_W-1:0] output_axis_tdata,
    output logic            output_axis_tvalid,
    input  logic            output_axis_tready,
    output logic            output_axis_tlast,
    output logic            busy,
    output logic            seeded,
    input  logic [MT_W-1:0] seed_val,
    input  logic            seed_start
);

    localparam int              N        = mt_n(MT_W);
    localparam int              M        = mt_m(MT_W);
    localparam int              SH       = mt_seed_shift(MT_W);
    localparam int              IW       = $clog2(N);
    localparam int              PW       = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [63:0]     F64      = mt_f(MT_W);
    localparam logic [63:0]     A64      = mt_a(MT_W);
    localparam logic [63:0]     UP64     = mt_upper(MT_W);
    localparam logic [MT_W-1:0] A        = A64[MT_W-1:0];
    localparam logic [MT_W-1:0] UPPER    = UP64[MT_W-1:0];
    localparam logic [MT_W-1:0] LOWER    = ~UPPER;
    localparam logic [MT_W-1:0] DEF_SEED = DEFAULT_SEED[MT_W-1:0];
    localparam logic [PW-1:0]   PKT_LAST = PW'((PKT_LEN > 0) ? PKT_LEN - 1 : 0);

    if (MT_W != 32 && MT_W != 64) begin : g_bad_width
        $error("axis_mt_prng: MT_W must be 32 or 64");
    end

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [6:0]      bit_q, bit_d;
    logic [MT_W-1:0] acc_q, acc_d;
    logic [MT_W-1:0] mcand_q, mcand_d;
    logic [IW-1:0]   mti_q, mti_d, mti1_q, mti1_d, mtim_q, mtim_d;
    logic            tvalid_q, tvalid_d, tlast_q, tlast_d, seeded_q, seeded_d;
    logic [MT_W-1:0] tdata_q, tdata_d;
    logic [PW-1:0]   pkt_q, pkt_d, pkt_nxt;

    logic [MT_W-1:0] mt_mem [N];
    logic            mem_we;
    logic [IW-1:0]   mem_waddr;
    logic [MT_W-1:0] mem_wdata;

    logic [MT_W-1:0] twist_y, twist_v, tempered, seed_wval;
    logic            accept, load, seed_wr, auto_seed;

`ifdef AXIS_MT_PRNG_DEFAULT_SEED_EN
    logic auto_seed_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) auto_seed_q <= 1'b1;
        else     auto_seed_q <= 1'b0;
    end
    assign auto_seed = auto_seed_q;
`else
    assign auto_seed = 1'b0;
`endif

    function automatic logic [IW-1:0] ptr_inc(input logic [IW-1:0] p);
        return (p == IW'(N - 1)) ? '0 : p + 1'b1;
    endfunction

    // One twist per accepted load; the written-back element is visible to later reads.
    assign twist_y   = (mt_mem[mti_q] & UPPER) | (mt_mem[mti1_q] & LOWER);
    assign twist_v   = mt_mem[mtim_q] ^ (twist_y >> 1) ^ (twist_y[0] ? A : '0);
    assign seed_wval = (idx_q == '0) ? acc_q : acc_q + MT_W'(idx_q);
    assign seed_wr   = (idx_q == '0) || (bit_q == 7'(MT_W));
    assign accept    = tvalid_q && output_axis_tready;
    assign load      = (state_q == RUN) && !seed_start && (!tvalid_q || output_axis_tready);
    assign pkt_nxt   = accept ? ((pkt_q == PKT_LAST) ? '0 : pkt_q + 1'b1) : pkt_q;

    axis_mt_prng_temper #(.MT_W(MT_W)) u_temper (
        .y_i (twist_v),
        .z_o (tempered)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        bit_d     = bit_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mti_d     = mti_q;
        mti1_d    = mti1_q;
        mtim_d    = mtim_q;
        tvalid_d  = accept ? 1'b0 : tvalid_q;
        tdata_d   = tdata_q;
        tlast_d   = tlast_q;
        pkt_d     = pkt_nxt;
        seeded_d  = seeded_q;
        mem_we    = 1'b0;
        mem_waddr = mti_q;
        mem_wdata = twist_v;
        unique case (state_q)
            IDLE: begin
                if (seed_start || auto_seed) begin
                    state_d = SEED;
                    idx_d   = '0;
                    bit_d   = '0;
                    acc_d   = auto_seed ? DEF_SEED : seed_val;
                end
            end
            SEED: begin
                if (idx_q == IW'(N)) begin
                    state_d  = RUN;
                    seeded_d = 1'b1;
                    pkt_d    = '0;
                    mti_d    = '0;
                    mti1_d   = IW'(1);
                    mtim_d   = IW'(M);
                end else if (seed_wr) begin
                    mem_we    = 1'b1;
                    mem_waddr = idx_q;
                    mem_wdata = seed_wval;
                    mcand_d   = seed_wval ^ (seed_wval >> SH);
                    acc_d     = '0;
                    bit_d     = '0;
                    idx_d     = idx_q + 1'b1;
                end else begin
                    // Serial shift-add: F is the multiplier, one bit per cycle.
                    acc_d   = acc_q + (F64[bit_q[5:0]] ? mcand_q : '0);
                    mcand_d = mcand_q << 1;
                    bit_d   = bit_q + 1'b1;
                end
            end
            RUN: begin
                if (seed_start) begin
                    state_d  = SEED;
                    seeded_d = 1'b0;
                    idx_d    = '0;
                    bit_d    = '0;
                    acc_d    = seed_val;
                end else if (load) begin
                    mem_we   = 1'b1;
                    tvalid_d = 1'b1;
                    tdata_d  = tempered;
                    tlast_d  = (PKT_LEN > 0) && (pkt_nxt == PKT_LAST);
                    mti_d    = ptr_inc(mti_q);
                    mti1_d   = ptr_inc(mti1_q);
                    mtim_d   = ptr_inc(mtim_q);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_we) mt_mem[mem_waddr] <= mem_wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            bit_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mti_q    <= '0;
            mti1_q   <= '0;
            mtim_q   <= '0;
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
            tlast_q  <= 1'b0;
            pkt_q    <= '0;
            seeded_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            bit_q    <= bit_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mti_q    <= mti_d;
            mti1_q   <= mti1_d;
            mtim_q   <= mtim_d;
            tvalid_q <= tvalid_d;
            tdata_q  <= tdata_d;
            tlast_q  <= tlast_d;
            pkt_q    <= pkt_d;
            seeded_q <= seeded_d;
        end
    end

    assign output_axis_tdata  = tdata_q;
    assign output_axis_tvalid = tvalid_q;
    assign output_axis_tlast  = tlast_q;
    assign busy               = (state_q == SEED);
    assign seeded             = seeded_q;

endmodule

// File: tb/tb_axis_mt_prng.sv
// tb/tb_axis_mt_prng.sv - directed bench: 32-bit unpacketised and 64-bit PKT_LEN=4 generators driven side by side.
module tb_axis_mt_prng;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] t32d, sv32;
    logic        t32v, t32r, t32l, busy32, seeded32, ss32;
    logic [63:0] t64d, sv64;
    logic        t64v, t64r, t64l, busy64, seeded64, ss64;

    axis_mt_prng #(.MT_W(32), .PKT_LEN(0)) dut32 (
        .clk(clk), .rst(rst),
        .output_axis_tdata(t32d), .output_axis_tvalid(t32v), .output_axis_tready(t32r),
        .output_axis_tlast(t32l), .busy(busy32), .seeded(seeded32),
        .seed_val(sv32), .seed_start(ss32)
    );

    axis_mt_prng #(.MT_W(64), .PKT_LEN(4)) dut64 (
        .clk(clk), .rst(rst),
        .output_axis_tdata(t64d), .output_axis_tvalid(t64v), .output_axis_tready(t64r),
        .output_axis_tlast(t64l), .busy(busy64), .seeded(seeded64),
        .seed_val(sv64), .seed_start(ss64)
    );

    int          n_assert = 0;
    int          n_fail   = 0;
    int          n32, n64, pk64, bc32, bc64, rmode32, guard;
    logic        stall32;
    logic [31:0] prev32, held32;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock of bookkeeping, run at the falling edge; inputs set here take effect at the next rising edge.
    task automatic step();
        @(negedge clk);
        ss32 = 1'b0;
        ss64 = 1'b0;
        if (stall32) begin
            check("stall32_tvalid", t32v, 1);
            check("stall32_tdata", t32d, prev32);
        end
        case (rmode32)
            0:       t32r = 1'b0;
            1:       t32r = 1'b1;
            default: t32r = ($urandom_range(0, 9) >= 3);
        endcase
        t64r = 1'b1;
        if (busy32) begin
            n32 = t32v ? -1 : 0;
            bc32++;
        end else if (bc32 != 0) begin
            check("busy32_cycles", bc32, 20561);
            bc32 = 0;
        end
        if (busy64) begin
            n64  = t64v ? -1 : 0;
            pk64 = 0;
            bc64++;
        end else if (bc64 != 0) begin
            check("busy64_cycles", bc64, 20217);
            bc64 = 0;
        end
        if (t32v && t32r) begin
            n32++;
            if (n32 == 0)     check("held32_word", t32d, held32);
            if (n32 == 1)     check("w1_32", t32d, 64'd3499211612);
            if (n32 == 10000) check("w10000_32", t32d, 64'd4123659995);
            check("tlast32_low", t32l, 0);
        end
        if (t64v && t64r) begin
            n64++;
            pk64++;
            if (n64 == 1)     check("w1_64", t64d, 64'd14514284786278117030);
            if (n64 == 10000) check("w10000_64", t64d, 64'd9981545732273789042);
            check("tlast64", t64l, (pk64 % 4) == 0);
        end
        stall32 = t32v && !t32r;
        prev32  = t32d;
    endtask

    initial begin
        rst = 1'b1; ss32 = 1'b0; ss64 = 1'b0; sv32 = '0; sv64 = '0; t32r = 1'b0; t64r = 1'b0;
        n32 = 0; n64 = 0; pk64 = 0; bc32 = 0; bc64 = 0; rmode32 = 0; stall32 = 1'b0;
        prev32 = '0; held32 = '0;
        #12;
        check("rst_tvalid32", t32v, 0);
        check("rst_tdata32", t32d, 0);
        check("rst_tlast32", t32l, 0);
        check("rst_busy32", busy32, 0);
        check("rst_seeded32", seeded32, 0);
        check("rst_tvalid64", t64v, 0);
        check("rst_tlast64", t64l, 0);
        check("rst_busy64", busy64, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) step();
`ifdef AXIS_MT_PRNG_DEFAULT_SEED_EN
        check("auto_busy32", busy32, 1);
        check("auto_busy64", busy64, 1);
`else
        check("idle_tvalid32", t32v, 0);
        check("idle_busy32", busy32, 0);
        check("idle_busy64", busy64, 0);
`endif

        ss32 = 1'b1; sv32 = 32'd5489;
        ss64 = 1'b1; sv64 = 64'd5489;
        rmode32 = 2;
        guard = 0;
        while (!(n32 >= 10000 && n64 >= 10000) && guard < 45000) begin
            step();
            guard++;
        end
        check("stream_done", (n32 >= 10000) && (n64 >= 10000), 1);
        check("seeded32_run", seeded32, 1);

        rmode32 = 0;
        step();
        step();
        guard = 0;
        while ((pk64 % 4) != 2 && guard < 8) begin
            step();
            guard++;
        end
        check("midpkt_reached", pk64 % 4, 2);
        check("held_valid32", t32v, 1);
        held32 = t32d;
        ss32 = 1'b1; sv32 = 32'd5489;
        ss64 = 1'b1; sv64 = 64'd5489;
        step();
        check("reseed_busy32", busy32, 1);
        check("reseed_seeded32", seeded32, 0);
        check("reseed_busy64", busy64, 1);
        repeat (100) step();
        ss32 = 1'b1; sv32 = 32'hDEAD_BEEF;
        step();
        check("ignored_busy32", busy32, 1);
        guard = 0;
        while ((busy32 || busy64) && guard < 25000) begin
            step();
            guard++;
        end
        check("reseed_done", busy32 || busy64, 0);
        rmode32 = 1;
        guard = 0;
        while (!(n32 >= 2 && n64 >= 9) && guard < 100) begin
            step();
            guard++;
        end
        check("post_reseed_words", (n32 >= 2) && (n64 >= 9), 1);

        rmode32 = 0;
        step();
        step();
        ss32 = 1'b1; sv32 = 32'd5489;
        step();
        repeat (10) step();
        check("pre_rst_busy32", busy32, 1);
        check("pre_rst_tvalid32", t32v, 1);
        check("pre_rst_seeded64", seeded64, 1);
        check("pre_rst_tvalid64", t64v, 1);
        #2 rst = 1'b1;
        #1;
        check("async_tvalid32", t32v, 0);
        check("async_tdata32", t32d, 0);
        check("async_busy32", busy32, 0);
        check("async_tvalid64", t64v, 0);
        check("async_seeded64", seeded64, 0);
        stall32 = 1'b0;
        bc32 = 0;
        bc64 = 0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) step();
`ifdef AXIS_MT_PRNG_DEFAULT_SEED_EN
        check("post_rst_auto_busy32", busy32, 1);
`else
        check("post_rst_idle_busy32", busy32, 0);
        check("post_rst_idle_tvalid32", t32v, 0);
`endif
        check("post_rst_seeded32", seeded32, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
